// File: rtl/complex_addsub_acc.sv
// Fixed-point complex add / subtract / conjugate-add unit with a
// running complex accumulator, joined stb/ack handshakes and sat/wrap.
module complex_addsub_acc #(
    parameter int WIDTH    = 32,
    parameter int GUARD    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a_real,
    input  logic [WIDTH-1:0] input_a_imag,
    input  logic [WIDTH-1:0] input_b_real,
    input  logic [WIDTH-1:0] input_b_imag,
    input  logic [1:0]       input_op,
    input  logic             input_last,
    input  logic             input_stb,
    output logic             input_ack,
    output logic [WIDTH-1:0] output_z_real,
    output logic [WIDTH-1:0] output_z_imag,
    output logic             output_z_ovf,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    localparam int XW = WIDTH + GUARD;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_CADD = 2'd2;
    localparam logic [1:0] OP_ACC  = 2'd3;

    localparam logic signed [XW-1:0] MAXV =
        {{(GUARD + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [XW-1:0] MINV =
        {{(GUARD + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        GET  = 2'd0,
        CALC = 2'd1,
        PUT  = 2'd2
    } state_t;

    state_t state;

    logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic [1:0]              op;
    logic                    last;
    logic signed [XW-1:0]    acc_re, acc_im;
    logic                    acc_ovf;

    logic signed [WIDTH:0]   s_re, s_im;
    logic signed [XW-1:0]    ax_re, ax_im;
    logic signed [XW-1:0]    an_re, an_im;
    logic signed [XW-1:0]    rin_re, rin_im;
    logic                    add_ovf;
    logic [WIDTH:0]          red_re, red_im;

    // Range-reduce a wide value to WIDTH bits; MSB of result flags overflow
    function automatic logic [WIDTH:0] reduce(input logic signed [XW-1:0] v);
        logic             o;
        logic [WIDTH-1:0] r;
        o = (v > MAXV) || (v < MINV);
        r = v[WIDTH-1:0];
        if (o && SATURATE)
            r = v[XW-1] ? MIN_W : MAX_W;
        return {o, r};
    endfunction

    // Datapath: WIDTH+1 component sums, guarded accumulator add, reduction
    always_comb begin
        s_re    = (op == OP_SUB) ? (WIDTH+1)'(a_re) - (WIDTH+1)'(b_re)
                                 : (WIDTH+1)'(a_re) + (WIDTH+1)'(b_re);
        s_im    = (op == OP_ADD) ? (WIDTH+1)'(a_im) + (WIDTH+1)'(b_im)
                                 : (WIDTH+1)'(a_im) - (WIDTH+1)'(b_im);
        ax_re   = XW'(a_re);
        ax_im   = XW'(a_im);
        an_re   = acc_re + ax_re;
        an_im   = acc_im + ax_im;
        add_ovf = ((acc_re[XW-1] == ax_re[XW-1]) &&
                   (an_re[XW-1] != acc_re[XW-1])) ||
                  ((acc_im[XW-1] == ax_im[XW-1]) &&
                   (an_im[XW-1] != acc_im[XW-1]));
        rin_re  = (op == OP_ACC) ? an_re : XW'(s_re);
        rin_im  = (op == OP_ACC) ? an_im : XW'(s_im);
        red_re  = reduce(rin_re);
        red_im  = reduce(rin_im);
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= GET;
            input_ack     <= 1'b0;
            output_z_stb  <= 1'b0;
            output_z_real <= '0;
            output_z_imag <= '0;
            output_z_ovf  <= 1'b0;
            acc_re        <= '0;
            acc_im        <= '0;
            acc_ovf       <= 1'b0;
            a_re          <= '0;
            a_im          <= '0;
            b_re          <= '0;
            b_im          <= '0;
            op            <= OP_ADD;
            last          <= 1'b0;
        end else begin
            unique case (state)
                GET: begin
                    if (input_stb && input_ack) begin
                        a_re      <= input_a_real;
                        a_im      <= input_a_imag;
                        b_re      <= input_b_real;
                        b_im      <= input_b_imag;
                        op        <= input_op;
                        last      <= input_last;
                        input_ack <= 1'b0;
                        state     <= CALC;
                    end else begin
                        input_ack <= 1'b1;
                    end
                end
                CALC: begin
                    if (op == OP_ACC && !last) begin
                        acc_re    <= an_re;
                        acc_im    <= an_im;
                        acc_ovf   <= acc_ovf | add_ovf;
                        input_ack <= 1'b1;
                        state     <= GET;
                    end else if (op == OP_ACC) begin
                        output_z_real <= red_re[WIDTH-1:0];
                        output_z_imag <= red_im[WIDTH-1:0];
                        output_z_ovf  <= acc_ovf | add_ovf |
                                         red_re[WIDTH] | red_im[WIDTH];
                        acc_re        <= '0;
                        acc_im        <= '0;
                        acc_ovf       <= 1'b0;
                        output_z_stb  <= 1'b1;
                        state         <= PUT;
                    end else begin
                        output_z_real <= red_re[WIDTH-1:0];
                        output_z_imag <= red_im[WIDTH-1:0];
                        output_z_ovf  <= red_re[WIDTH] | red_im[WIDTH];
                        output_z_stb  <= 1'b1;
                        state         <= PUT;
                    end
                end
                PUT: begin
                    if (output_z_ack) begin
                        output_z_stb <= 1'b0;
                        input_ack    <= 1'b1;
                        state        <= GET;
                    end
                end
                default: begin
                    state <= GET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_addsub_acc.sv
// Randomised self-checking bench for complex_addsub_acc; runs a saturating
// and a wrapping instance side by side against an arithmetic model.
module tb_complex_addsub_acc;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int XW = W + G;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_re, a_im, b_re, b_im;
    logic [1:0]   op;
    logic         last, in_stb, z_ack;

    logic         s_ack, s_ovf, s_stb;
    logic [W-1:0] s_re, s_im;
    logic         w_ack, w_ovf, w_stb;
    logic [W-1:0] w_re, w_im;

    int n_cmp = 0;
    int n_bad = 0;

    longint m_acc_re, m_acc_im;
    bit     m_acc_ovf;

    always #5 clk = ~clk;

    complex_addsub_acc #(.WIDTH(W), .GUARD(G), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst),
        .input_a_real(a_re), .input_a_imag(a_im),
        .input_b_real(b_re), .input_b_imag(b_im),
        .input_op(op), .input_last(last),
        .input_stb(in_stb), .input_ack(s_ack),
        .output_z_real(s_re), .output_z_imag(s_im),
        .output_z_ovf(s_ovf), .output_z_stb(s_stb),
        .output_z_ack(z_ack)
    );

    complex_addsub_acc #(.WIDTH(W), .GUARD(G), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst),
        .input_a_real(a_re), .input_a_imag(a_im),
        .input_b_real(b_re), .input_b_imag(b_im),
        .input_op(op), .input_last(last),
        .input_stb(in_stb), .input_ack(w_ack),
        .output_z_real(w_re), .output_z_imag(w_im),
        .output_z_ovf(w_ovf), .output_z_stb(w_stb),
        .output_z_ack(z_ack)
    );

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint m;
        m = v & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1)))
            m -= (longint'(1) << n);
        return m;
    endfunction

    task automatic reduce_m(input longint v, input bit sat,
                            output longint r, output bit o);
        longint mx, mn;
        mx = (longint'(1) << (W - 1)) - 1;
        mn = -(longint'(1) << (W - 1));
        o  = (v > mx) || (v < mn);
        if (!o)
            r = v;
        else if (sat)
            r = (v > mx) ? mx : mn;
        else
            r = wrapn(v, W);
    endtask

    task automatic acc_add(inout longint acc, input longint a);
        longint hi, lo;
        hi  = (longint'(1) << (XW - 1)) - 1;
        lo  = -(longint'(1) << (XW - 1));
        acc = acc + a;
        if (acc > hi || acc < lo) begin
            m_acc_ovf = 1'b1;
            acc = wrapn(acc, XW);
        end
    endtask

    // Reference: result for both the saturating and wrapping instance
    task automatic model_op(input logic [1:0] o, input longint ar,
                            input longint ai, input longint br,
                            input longint bi, input bit lst,
                            output bit has,
                            output longint zr_s, output longint zi_s,
                            output bit ov_s,
                            output longint zr_w, output longint zi_w,
                            output bit ov_w);
        longint re, im;
        bit     o1, o2;
        has = 1'b1;
        re  = 0;
        im  = 0;
        case (o)
            2'd0: begin re = ar + br; im = ai + bi; end
            2'd1: begin re = ar - br; im = ai - bi; end
            2'd2: begin re = ar + br; im = ai - bi; end
            default: begin
                acc_add(m_acc_re, ar);
                acc_add(m_acc_im, ai);
                re = m_acc_re;
                im = m_acc_im;
                if (!lst) has = 1'b0;
            end
        endcase
        reduce_m(re, 1'b1, zr_s, o1);
        reduce_m(im, 1'b1, zi_s, o2);
        ov_s = o1 | o2;
        reduce_m(re, 1'b0, zr_w, o1);
        reduce_m(im, 1'b0, zi_w, o2);
        ov_w = o1 | o2;
        if (o == 2'd3 && lst) begin
            ov_s = ov_s | m_acc_ovf;
            ov_w = ov_w | m_acc_ovf;
            m_acc_re  = 0;
            m_acc_im  = 0;
            m_acc_ovf = 1'b0;
        end
    endtask

    task automatic chk_out(input string tag, input longint zr_s,
                           input longint zi_s, input bit ov_s,
                           input longint zr_w, input longint zi_w,
                           input bit ov_w);
        chk({tag, "_stb_s"}, s_stb, 1);
        chk({tag, "_stb_w"}, w_stb, 1);
        chk({tag, "_re_s"}, $signed(s_re), zr_s);
        chk({tag, "_im_s"}, $signed(s_im), zi_s);
        chk({tag, "_ovf_s"}, s_ovf, ov_s);
        chk({tag, "_re_w"}, $signed(w_re), zr_w);
        chk({tag, "_im_w"}, $signed(w_im), zi_w);
        chk({tag, "_ovf_w"}, w_ovf, ov_w);
    endtask

    task automatic do_op(input logic [1:0] o, input longint ar,
                         input longint ai, input longint br,
                         input longint bi, input bit lst, input int hold);
        bit     has, ov_s, ov_w;
        longint zr_s, zi_s, zr_w, zi_w;
        int     n;
        model_op(o, ar, ai, br, bi, lst, has,
                 zr_s, zi_s, ov_s, zr_w, zi_w, ov_w);
        a_re   = ar[W-1:0];
        a_im   = ai[W-1:0];
        b_re   = br[W-1:0];
        b_im   = bi[W-1:0];
        op     = o;
        last   = lst;
        in_stb = 1'b1;
        n = 0;
        while (!s_ack && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ack) begin
            chk("in_ack_timeout", s_ack, 1);
            in_stb = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_stb = 1'b0;
        chk("ack_low_after_xfer", s_ack, 0);
        chk("stb_early", s_stb, 0);
        @(posedge clk); #1;
        if (!has) begin
            chk("acc_no_stb", s_stb | w_stb, 0);
            return;
        end
        chk_out("res", zr_s, zi_s, ov_s, zr_w, zi_w, ov_w);
        if (hold > 0) begin
            in_stb = 1'b1;
            op     = 2'd0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk_out("hold", zr_s, zi_s, ov_s, zr_w, zi_w, ov_w);
                chk("hold_ack_low", s_ack | w_ack, 0);
            end
            in_stb = 1'b0;
        end
        z_ack = 1'b1;
        @(posedge clk); #1;
        z_ack = 1'b0;
        chk("stb_drop", s_stb | w_stb, 0);
        chk("ack_after_put", s_ack, 1);
    endtask

    function automatic longint rnd();
        logic [W-1:0] t;
        case ($urandom_range(0, 5))
            0: return 32767;
            1: return -32768;
            default: begin
                t = W'($urandom);
                return longint'($signed(t));
            end
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ro;
        m_acc_re  = 0;
        m_acc_im  = 0;
        m_acc_ovf = 1'b0;
        rst    = 1'b1;
        in_stb = 1'b0;
        z_ack  = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        op = 2'd0; last = 1'b0;
        #1;
        chk("rst_ack", s_ack, 0);
        chk("rst_stb", s_stb, 0);
        chk("rst_re", $signed(s_re), 0);
        chk("rst_ovf", s_ovf, 0);
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("ack_first_edge", s_ack, 1);

        do_op(2'd0, 100, -50, 20, 30, 1'b0, 0);
        do_op(2'd1, 32767, -32768, -1, 1, 1'b0, 0);
        do_op(2'd2, 5, 5, 3, 7, 1'b0, 0);
        do_op(2'd0, 32767, 0, 1, 0, 1'b0, 0);

        for (int i = 0; i < 4; i++)
            do_op(2'd3, 1000, -1000, 0, 0, i == 3, 0);
        do_op(2'd3, 7, 7, 0, 0, 1'b1, 0);

        do_op(2'd0, rnd(), rnd(), rnd(), rnd(), 1'b0, 10);

        do_op(2'd3, 1, 1, 0, 0, 1'b0, 0);
        do_op(2'd0, 300, -400, 11, 22, 1'b0, 0);
        do_op(2'd3, 2, 2, 0, 0, 1'b1, 0);

        for (int i = 0; i < 20; i++)
            do_op(2'd3, 32767, -32768, 0, 0, i == 19, 0);

        do_op(2'd3, 10, 10, 0, 0, 1'b0, 0);
        do_op(2'd3, 10, 10, 0, 0, 1'b0, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_re_s", $signed(s_re), 0);
        chk("arst_im_s", $signed(s_im), 0);
        chk("arst_ovf_s", s_ovf, 0);
        chk("arst_stb", s_stb | w_stb, 0);
        chk("arst_ack", s_ack | w_ack, 0);
        chk("arst_re_w", $signed(w_re), 0);
        m_acc_re  = 0;
        m_acc_im  = 0;
        m_acc_ovf = 1'b0;
        #3 rst = 1'b0;
        do_op(2'd3, 5, -5, 0, 0, 1'b1, 0);

        for (int i = 0; i < 200; i++) begin
            ro = 2'($urandom_range(0, 3));
            do_op(ro, rnd(), rnd(), rnd(), rnd(),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2));
        end
        do_op(2'd3, 0, 0, 0, 0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
